// File: rtl/pipe_id_ex_skid_if.sv
// ID->EX handshake bundle: upstream ID payload channel and downstream EX payload channel.
// The stage uses the slave modport; the environment driving ID and consuming EX uses master.
interface pipe_id_ex_skid_if #(
    parameter int DW  = 8,
    parameter int RW  = 3,
    parameter int OPW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_opcode;
    logic [DW-1:0]  in_a;
    logic [DW-1:0]  in_b;
    logic [RW-1:0]  in_rs;
    logic [RW-1:0]  in_rt;
    logic [RW-1:0]  in_rd;

    logic           out_valid;
    logic           out_ready;
    logic [OPW-1:0] out_opcode;
    logic [DW-1:0]  out_a;
    logic [DW-1:0]  out_b;
    logic [RW-1:0]  out_rs;
    logic [RW-1:0]  out_rt;
    logic [RW-1:0]  out_rd;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_rs, in_rt, in_rd, out_ready,
        output in_ready, out_valid, out_opcode, out_a, out_b, out_rs, out_rt, out_rd
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_rs, in_rt, in_rd, out_ready,
        input  in_ready, out_valid, out_opcode, out_a, out_b, out_rs, out_rt, out_rd
    );
endinterface

// File: rtl/pipe_id_ex_skid.sv
// ID->EX pipeline stage built as a two-entry skid buffer (main + skid register).
// in_ready is registered (NOT skid valid), so out_ready never reaches in_ready combinationally.
// Invalid entries always carry an all-zero payload, so an empty stage emits a NOP bubble.
// Optional feature: define PIPE_ID_EX_PERF_EN to add saturating stall/bubble counters.
module pipe_id_ex_skid #(
    parameter int DW  = 8,
    parameter int RW  = 3,
    parameter int OPW = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    pipe_id_ex_skid_if.slave        bus
`ifdef PIPE_ID_EX_PERF_EN
    ,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             bubble_cnt
`endif
);

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [RW-1:0]  rs;
        logic [RW-1:0]  rt;
        logic [RW-1:0]  rd;
    } pld_t;

    pld_t in_pld;
    pld_t main_p1, skid_p1;
    pld_t main_nxt, skid_nxt;
    logic vld_p1, skid_vld_p1;
    logic vld_nxt, skid_vld_nxt;
    logic in_rdy_p1;
    logic in_xfer, out_xfer;

    assign in_pld   = '{op: bus.in_opcode, a: bus.in_a, b: bus.in_b,
                        rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd};
    assign in_xfer  = bus.in_valid & in_rdy_p1;
    assign out_xfer = vld_p1 & bus.out_ready;

    // Next-state of the two entries: refill main when it is empty or draining, else park input in skid.
    always_comb begin
        main_nxt     = main_p1;
        skid_nxt     = skid_p1;
        vld_nxt      = vld_p1;
        skid_vld_nxt = skid_vld_p1;
        if (!vld_p1 || out_xfer) begin
            if (skid_vld_p1) begin
                // Oldest payload first: skid moves up; input is blocked while skid is full.
                main_nxt     = skid_p1;
                vld_nxt      = 1'b1;
                skid_nxt     = '0;
                skid_vld_nxt = 1'b0;
            end else if (in_xfer) begin
                main_nxt = in_pld;
                vld_nxt  = 1'b1;
            end else begin
                main_nxt = '0;
                vld_nxt  = 1'b0;
            end
        end else if (in_xfer) begin
            skid_nxt     = in_pld;
            skid_vld_nxt = 1'b1;
        end
    end

    // ---- stage p1: main/skid registers; reset and flush empty the stage and zero payloads ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_p1     <= '0;
            skid_p1     <= '0;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            in_rdy_p1   <= 1'b1;
        end else if (flush) begin
            main_p1     <= '0;
            skid_p1     <= '0;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            in_rdy_p1   <= 1'b1;
        end else begin
            main_p1     <= main_nxt;
            skid_p1     <= skid_nxt;
            vld_p1      <= vld_nxt;
            skid_vld_p1 <= skid_vld_nxt;
            in_rdy_p1   <= ~skid_vld_nxt;
        end
    end

    assign bus.in_ready   = in_rdy_p1;
    assign bus.out_valid  = vld_p1;
    assign bus.out_opcode = main_p1.op;
    assign bus.out_a      = main_p1.a;
    assign bus.out_b      = main_p1.b;
    assign bus.out_rs     = main_p1.rs;
    assign bus.out_rt     = main_p1.rt;
    assign bus.out_rd     = main_p1.rd;

`ifdef PIPE_ID_EX_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Performance counters: survive flush, cleared only by reset, stick at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (vld_p1 && !bus.out_ready)
                stall_cnt <= sat_inc16(stall_cnt);
            if (!vld_p1 && bus.out_ready)
                bubble_cnt <= sat_inc16(bubble_cnt);
        end
    end
`endif

endmodule
